// File: rtl/pipelined_addsub.sv
// Segmented, pipelined add/subtract unit: one SEG-bit slice of the carry chain per stage,
// with a valid/ready handshake where the whole pipeline advances or stalls as one.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NSEG = WIDTH / SEG;
    localparam logic [WIDTH-1:0] SEGMASK = WIDTH'({SEG{1'b1}});

    logic             r_vld [NSEG];
    logic             r_c   [NSEG];
    logic [WIDTH-1:0] r_a   [NSEG];
    logic [WIDTH-1:0] r_b   [NSEG];
    logic [WIDTH-1:0] r_s   [NSEG];
    logic             r_ovf;

    logic             w_adv;
    logic [WIDTH-1:0] w_bIn;
    logic             w_vldIn [NSEG];
    logic             w_cIn   [NSEG];
    logic [WIDTH-1:0] w_aIn   [NSEG];
    logic [WIDTH-1:0] w_bOp   [NSEG];
    logic [WIDTH-1:0] w_sIn   [NSEG];
    logic [WIDTH-1:0] w_sNext [NSEG];
    logic [SEG-1:0]   w_segA  [NSEG];
    logic [SEG-1:0]   w_segB  [NSEG];
    logic [SEG:0]     w_sum   [NSEG];
    logic             w_ovf;

    assign w_adv    = out_ready | ~r_vld[NSEG-1];
    assign in_ready = w_adv;
    assign w_bIn    = sub ? ~B : B;

    // Stage 0 draws from the ports; later stages draw from the previous stage's registers.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_vldIn[k] = in_valid;
            assign w_aIn[k]   = A;
            assign w_bOp[k]   = w_bIn;
            assign w_cIn[k]   = sub | Cin;
            assign w_sIn[k]   = '0;
        end else begin : g_next
            assign w_vldIn[k] = r_vld[k-1];
            assign w_aIn[k]   = r_a[k-1];
            assign w_bOp[k]   = r_b[k-1];
            assign w_cIn[k]   = r_c[k-1];
            assign w_sIn[k]   = r_s[k-1];
        end

        assign w_segA[k]  = w_aIn[k][k*SEG +: SEG];
        assign w_segB[k]  = w_bOp[k][k*SEG +: SEG];
        assign w_sum[k]   = {1'b0, w_segA[k]} + {1'b0, w_segB[k]} + {{SEG{1'b0}}, w_cIn[k]};
        assign w_sNext[k] = (w_sIn[k] & ~(SEGMASK << (k*SEG)))
                          | (WIDTH'(w_sum[k][SEG-1:0]) << (k*SEG));
    end

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign w_ovf = w_segA[NSEG-1][SEG-1] ^ w_segB[NSEG-1][SEG-1]
                 ^ w_sum[NSEG-1][SEG-1] ^ w_sum[NSEG-1][SEG];

    // Bubbles advance as cleared valid bits but leave stage data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                r_vld[k] <= 1'b0;
                r_c[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < NSEG; k++) begin
                r_vld[k] <= w_vldIn[k];
                if (w_vldIn[k]) begin
                    r_c[k] <= w_sum[k][SEG];
                    r_a[k] <= w_aIn[k];
                    r_b[k] <= w_bOp[k];
                    r_s[k] <= w_sNext[k];
                end
            end
            if (w_vldIn[NSEG-1]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = r_vld[NSEG-1];
    assign S         = r_s[NSEG-1];
    assign Cout      = r_c[NSEG-1];
    assign V         = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases, a scripted stall, a reset flush and a
// randomized stream checked against an arithmetic reference model and result queue.
module tb_pipelined_addsub;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sb;
    } bundle_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;

    logic        inValid, inReady, outValid, outReady;
    logic [31:0] a, b, s;
    logic        cin, subMode, cout, v;

    logic        inValid64, inReady64, outValid64, outReady64;
    logic [63:0] a64, b64, s64;
    logic        cin64, sub64, cout64, v64;

    logic        inValidOne, inReadyOne, outValidOne, outReadyOne;
    logic [31:0] aOne, bOne, sOne;
    logic        cinOne, subOne, coutOne, vOne;

    int checks = 0;
    int errors = 0;

    bundle_t     pending[$];
    logic [33:0] expQ[$];
    int          received;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .SEG(16)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .A(a), .B(b), .Cin(cin), .sub(subMode),
        .out_valid(outValid), .out_ready(outReady), .S(s), .Cout(cout), .V(v)
    );

    pipelined_addsub #(.WIDTH(64), .SEG(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(inValid64), .in_ready(inReady64),
        .A(a64), .B(b64), .Cin(cin64), .sub(sub64),
        .out_valid(outValid64), .out_ready(outReady64), .S(s64), .Cout(cout64), .V(v64)
    );

    pipelined_addsub #(.WIDTH(32), .SEG(32)) dutOne (
        .clk(clk), .rst(rst), .in_valid(inValidOne), .in_ready(inReadyOne),
        .A(aOne), .B(bOne), .Cin(cinOne), .sub(subOne),
        .out_valid(outValidOne), .out_ready(outReadyOne), .S(sOne), .Cout(coutOne), .V(vOne)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result packed as {V, Cout, S}, from plain unsigned and signed integer arithmetic.
    function automatic logic [33:0] refModel(input bundle_t bd);
        longint unsigned ua, ub, us;
        longint          sa, sbv, ss;
        logic            c, ov;
        ua  = {32'd0, bd.a};
        ub  = {32'd0, bd.b};
        sa  = $signed(bd.a);
        sbv = $signed(bd.b);
        if (bd.sb) begin
            us = ua - ub;
            c  = (ua >= ub);
            ss = sa - sbv;
        end else begin
            us = ua + ub + {63'd0, bd.cin};
            c  = (us >= 64'h1_0000_0000);
            ss = sa + sbv + longint'({63'd0, bd.cin});
        end
        ov = (ss > SMAX) || (ss < SMIN);
        return {ov, c, us[31:0]};
    endfunction

    function automatic logic [65:0] refModel64(input logic [63:0] x, input logic [63:0] y,
                                               input logic ci, input logic sb);
        logic [63:0] yy;
        logic [64:0] full;
        logic        ov;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {64'd0, (sb | ci)};
        ov   = (x[63] == yy[63]) && (full[63] != x[63]);
        return {ov, full};
    endfunction

    function automatic bundle_t mkBundle(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
        bundle_t bd;
        bd.a = x; bd.b = y; bd.cin = ci; bd.sb = sb;
        return bd;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bundle_t bd);
        inValid = 1'b1;
        a       = bd.a;
        b       = bd.b;
        cin     = bd.cin;
        subMode = bd.sb;
    endtask

    // One bundle through the 32/16 unit with the consumer always ready; checks 2-cycle latency.
    task automatic sendAndCheck(input string tag, input bundle_t bd);
        outReady = 1'b1;
        applyStimulus(bd);
        #1;
        checkOutput({tag, "_inReady"}, {63'd0, inReady}, 64'd1);
        tick();
        inValid = 1'b0;
        checkOutput({tag, "_early"}, {63'd0, outValid}, 64'd0);
        tick();
        checkOutput({tag, "_valid"}, {63'd0, outValid}, 64'd1);
        checkOutput(tag, {30'd0, v, cout, s}, {30'd0, refModel(bd)});
        tick();
    endtask

    task automatic send64(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic ci, input logic sb);
        logic [65:0] e;
        e          = refModel64(x, y, ci, sb);
        inValid64  = 1'b1;
        a64        = x;
        b64        = y;
        cin64      = ci;
        sub64      = sb;
        tick();
        inValid64  = 1'b0;
        repeat (2) tick();
        checkOutput({tag, "_early"}, {63'd0, outValid64}, 64'd0);
        tick();
        checkOutput({tag, "_valid"}, {63'd0, outValid64}, 64'd1);
        checkOutput({tag, "_S"}, s64, e[63:0]);
        checkOutput({tag, "_CoutV"}, {62'd0, v64, cout64}, {62'd0, e[65], e[64]});
        tick();
    endtask

    task automatic sendOne(input string tag, input bundle_t bd);
        inValidOne = 1'b1;
        aOne       = bd.a;
        bOne       = bd.b;
        cinOne     = bd.cin;
        subOne     = bd.sb;
        tick();
        inValidOne = 1'b0;
        checkOutput({tag, "_valid"}, {63'd0, outValidOne}, 64'd1);
        checkOutput(tag, {30'd0, vOne, coutOne, sOne}, {30'd0, refModel(bd)});
        tick();
    endtask

    // Drains 'pending' through the 32/16 unit, scoreboarding results and checking stall behaviour.
    task automatic runStream(input int budget, input bit randomMode, input int stallFrom, input int stallTo);
        int          cyc = 0;
        bit          presenting = 1'b0;
        bit          heldValid  = 1'b0;
        logic [33:0] heldOut = '0;
        received = 0;
        while ((pending.size() > 0 || expQ.size() > 0) && cyc < budget) begin
            if (randomMode) outReady = ($urandom_range(0, 3) != 0);
            else            outReady = !(cyc >= stallFrom && cyc <= stallTo);
            if (!presenting && pending.size() > 0)
                presenting = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (presenting) applyStimulus(pending[0]);
            else            inValid = 1'b0;
            #1;
            if (heldValid) begin
                checkOutput("holdValid", {63'd0, outValid}, 64'd1);
                checkOutput("holdStable", {30'd0, v, cout, s}, {30'd0, heldOut});
            end
            if (!randomMode && cyc >= stallFrom && cyc <= stallTo) begin
                checkOutput("stallInReady", {63'd0, inReady}, 64'd0);
                checkOutput("stallFirst", {32'd0, s}, 64'd2);
            end
            checkOutput("inReadyRule", {63'd0, inReady}, {63'd0, outReady | ~outValid});
            heldValid = 1'b0;
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious", 64'd1, {63'd0, outValid & ~outValid});
                end else begin
                    checkOutput("result", {30'd0, v, cout, s}, {30'd0, expQ.pop_front()});
                    received++;
                end
            end else if (outValid) begin
                heldValid = 1'b1;
                heldOut   = {v, cout, s};
            end
            if (inValid && inReady) begin
                expQ.push_back(refModel(pending.pop_front()));
                presenting = 1'b0;
            end
            tick();
            cyc++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("streamDrained", 64'(pending.size() + expQ.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        inValid = 1'b0; outReady = 1'b1; a = '0; b = '0; cin = 1'b0; subMode = 1'b0;
        inValid64 = 1'b0; outReady64 = 1'b1; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;
        inValidOne = 1'b0; outReadyOne = 1'b1; aOne = '0; bOne = '0; cinOne = 1'b0; subOne = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        checkOutput("rstOutValid", {63'd0, outValid}, 64'd0);
        checkOutput("rstS", {32'd0, s}, 64'd0);
        checkOutput("rstCoutV", {62'd0, cout, v}, 64'd0);
        checkOutput("rstInReady", {63'd0, inReady}, 64'd1);

        sendAndCheck("addWrap", mkBundle(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0));
        sendAndCheck("subNeg", mkBundle(32'd5, 32'd7, 1'b0, 1'b1));
        sendAndCheck("subOvf", mkBundle(32'h8000_0000, 32'h1, 1'b0, 1'b1));
        sendAndCheck("addOvf", mkBundle(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0));
        sendAndCheck("addCin", mkBundle(32'd1, 32'd2, 1'b1, 1'b0));
        sendAndCheck("subCinIgnored", mkBundle(32'd10, 32'd3, 1'b1, 1'b1));
        sendAndCheck("segCarry", mkBundle(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0));

        for (int i = 0; i < 4; i++)
            pending.push_back(mkBundle(32'(i + 1), 32'(i + 1), 1'b0, 1'b0));
        runStream(40, 1'b0, 2, 3);
        checkOutput("stallCount", 64'(received), 64'd4);

        applyStimulus(mkBundle(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0));
        tick();
        inValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("flushValid", {63'd0, outValid}, 64'd0);
        checkOutput("flushS", {32'd0, s}, 64'd0);
        checkOutput("flushCout", {63'd0, cout}, 64'd0);
        tick();
        checkOutput("flushNoGhost", {63'd0, outValid}, 64'd0);
        sendAndCheck("afterFlush", mkBundle(32'd3, 32'd4, 1'b0, 1'b0));

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 4) == 0) ra = {ra[31], {31{~ra[31]}}};
            pending.push_back(mkBundle(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end
        runStream(3000, 1'b1, 0, 0);
        checkOutput("randomCount", 64'(received), 64'd200);

        send64("w64Seg", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        send64("w64Wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        send64("w64Sub", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            send64("w64Rand", {$urandom(), $urandom()}, {$urandom(), $urandom()},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        sendOne("oneAdd", mkBundle(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0));
        sendOne("oneSub", mkBundle(32'h8000_0000, 32'h1, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++)
            sendOne("oneRand", mkBundle($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                                        1'($urandom_range(0, 1))));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, segmented, pipelined add/subtract unit that generalises the team's fixed 32-bit cascaded adder. Operands are split into SEG-bit segments, and one segment is resolved per pipeline stage, so the carry chain per cycle is SEG bits regardless of WIDTH. It adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure. It sits in the datapath wherever a wide adder must meet timing at full clock rate.

## Interface
- WIDTH, 32: operand and result width; must be a positive multiple of SEG.
- SEG, 16: segment width resolved per stage; NSEG = WIDTH/SEG stages.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle present.
- in_ready  out  1  unit accepts the bundle this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: S = A + B + Cin; 1: S = A - B (A + ~B + 1, Cin ignored).
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- S  out  WIDTH  sum/difference, modulo 2^WIDTH.
- Cout  out  1  carry out of bit WIDTH-1 (in sub mode 1 = no borrow).
- V  out  1  signed two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Synchronous reset and active-high polarity are fixed: reset is sampled on the rising edge of clk.
- The pipeline has NSEG stages; stage k (0..NSEG-1) holds a valid bit, the carry out of segment k, result segments 0..k, and operand segments k+1..NSEG-1 (B already inverted if sub).
- Stage 0 at accept: computes segment 0 = A[SEG-1:0] + B'[SEG-1:0] + c0.
  - B' = sub ? ~B : B.
  - c0 = sub ? 1 : Cin.
- Stage k>0 computes segment k from its delayed operand segments plus the registered carry of stage k-1.
- The last stage drives S, Cout, out_valid; V is computed in the last stage from the MSB carries.
- Global advance: adv = out_ready | ~out_valid; in_ready = adv.
- When adv=1, every stage loads from its predecessor; stage 0 loads in_valid & in_ready.
- When adv=0, all stages hold, including valid bits and data.
- Bubbles propagate as invalid stages. A stall holds bubbles in place; they are not compressed.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- No state machine beyond the per-stage valid bits; data never reorders or drops.
- Arithmetic is unsigned modulo 2^WIDTH; V interprets A, B, S as signed.

## Timing
- Reset values: all stage valid bits 0, out_valid 0, S 0, Cout 0, V 0. in_ready is 1 after reset (output empty).
- Latency: a bundle accepted at edge t appears with out_valid=1 after edge t+NSEG-1, i.e. NSEG cycles (2 for defaults), when there are no stalls.
- Throughput: one result per cycle while out_ready=1.
- While out_valid=1 and out_ready=0: S, Cout, V stay stable and in_ready=0. A bundle presented then is not accepted and must be held by the source.
- Simultaneous output take and input accept in the same cycle is legal; the pipeline stays full.
- rst asserted mid-operation: all in-flight bundles are discarded. Outputs take reset values after that edge, and no result from before reset ever appears.
- NSEG=1 (SEG=WIDTH) degenerates to a single registered adder with latency 1; the same handshake rules apply.
- Carry crosses at most one segment boundary per cycle; the combinational path is one SEG-bit add plus the handshake logic.

## Test plan
- Defaults, A=0xFFFFFFFF, B=0x00000001, Cin=0, sub=0 -> 2 cycles later S=0x00000000, Cout=1, V=0.
- Defaults, A=5, B=7, sub=1 -> S=0xFFFFFFFE, Cout=0, V=0. Then A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, Cout=1, V=1.
- Defaults, A=0x7FFFFFFF, B=1, Cin=0 -> S=0x80000000, Cout=0, V=1. Then A=1, B=2, Cin=1 -> S=4, Cout=0, V=0.
- Stream 4 back-to-back adds (i+1)+(i+1) for i=0..3, with out_ready=0 on the cycle the first result appears and the next cycle.
  - in_ready=0 during the stall.
  - The first result 2 holds stable while stalled.
  - Results then appear as 2, 4, 6, 8 in order, with none lost or duplicated.
- Accept A=0xFFFFFFFF, B=1, then assert rst for one cycle before the result appears -> out_valid stays 0, S=0, Cout=0. The next accepted bundle 3+4 yields 7 after 2 cycles.
- WIDTH=64, SEG=16: A=0x0000FFFFFFFFFFFF, B=1 -> after 4 cycles S=0x0001000000000000, Cout=0. Also A=0xFFFFFFFFFFFFFFFF, B=0, Cin=1 -> S=0, Cout=1.
